// File: rtl/gray_step_monitor.sv
// Checker for a two-digit (2 x 4-bit) Gray up/down counter: decodes each sample,
// verifies every step and carry against the shared en/dir controls, counts errors and wraps.
module gray_step_monitor #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             dir,
   input  logic [7:0]       gray_in,
   input  logic             cout_in,
   output logic [7:0]       bin_out,
   output logic             bin_valid,
   output logic             step_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_ERR   = 2'd2;

   function automatic logic [3:0] dec4(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      b[2] = b[3] ^ g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      return b;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [7:0]       prev_bin_q;
   logic             en_q, dir_q;
   logic [7:0]       bin_out_q;
   logic             bin_valid_q, bin_valid_d;
   logic             step_err_q, step_err_d;
   logic             err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

   logic [7:0] cur_bin;
   logic [7:0] exp_bin;
   logic       carry_exp;
   logic       step_mis;
   logic       carry_mis;
   logic       wrap_hit;

   assign cur_bin = {dec4(gray_in[7:4]), dec4(gray_in[3:0])};

   // en_q/dir_q are the controls the counter used for the step now being observed;
   // the carry output reflects the controls currently presented to it.
   assign exp_bin   = en_q ? (dir_q ? prev_bin_q + 8'd1 : prev_bin_q - 8'd1) : prev_bin_q;
   assign carry_exp = en & (dir ? (cur_bin == 8'hFF) : (cur_bin == 8'h00));
   assign step_mis  = (cur_bin != exp_bin);
   assign carry_mis = (cout_in != carry_exp);
   assign wrap_hit  = en_q & ~step_mis &
                      (( dir_q & (prev_bin_q == 8'hFF) & (cur_bin == 8'h00)) |
                       (~dir_q & (prev_bin_q == 8'h00) & (cur_bin == 8'hFF)));

   always_comb begin
      state_d      = state_q;
      bin_valid_d  = bin_valid_q;
      step_err_d   = 1'b0;
      err_sticky_d = err_sticky_q;
      err_cnt_d    = err_cnt_q;
      wrap_cnt_d   = wrap_cnt_q;
      if (clr) begin
         state_d      = ST_INIT;
         bin_valid_d  = 1'b0;
         err_sticky_d = 1'b0;
         err_cnt_d    = '0;
         wrap_cnt_d   = '0;
      end else begin
         case (state_q)
            ST_INIT, ST_ERR: begin
               // Priming cycle: the sample only seeds prev_bin, so one corruption gives one pulse.
               bin_valid_d = 1'b1;
               state_d     = ST_TRACK;
            end
            ST_TRACK: begin
               if (step_mis || carry_mis) begin
                  step_err_d   = 1'b1;
                  err_sticky_d = 1'b1;
                  state_d      = ST_ERR;
                  if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
               end
               if (wrap_hit && (wrap_cnt_q != {CNT_W{1'b1}})) wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         prev_bin_q   <= '0;
         en_q         <= 1'b0;
         dir_q        <= 1'b0;
         bin_out_q    <= '0;
         bin_valid_q  <= 1'b0;
         step_err_q   <= 1'b0;
         err_sticky_q <= 1'b0;
         err_cnt_q    <= '0;
         wrap_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         prev_bin_q   <= cur_bin;
         en_q         <= en;
         dir_q        <= dir;
         bin_out_q    <= cur_bin;
         bin_valid_q  <= bin_valid_d;
         step_err_q   <= step_err_d;
         err_sticky_q <= err_sticky_d;
         err_cnt_q    <= err_cnt_d;
         wrap_cnt_q   <= wrap_cnt_d;
      end
   end

   assign bin_out    = bin_out_q;
   assign bin_valid  = bin_valid_q;
   assign step_err   = step_err_q;
   assign err_sticky = err_sticky_q;
   assign err_cnt    = err_cnt_q;
   assign wrap_cnt   = wrap_cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: a behavioural Gray counter drives the monitor; outputs are
// compared each cycle against a rule-level reference model plus directed table and sequences.
module tb_gray_step_monitor;

   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             en = 1'b0;
   logic             dir = 1'b0;
   logic [7:0]       gray_in = 8'h00;
   logic             cout_in = 1'b0;
   logic [7:0]       bin_out;
   logic             bin_valid;
   logic             step_err;
   logic             err_sticky;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] wrap_cnt;
   logic [1:0]       dbg_state;

   gray_step_monitor #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dir(dir),
      .gray_in(gray_in), .cout_in(cout_in),
      .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err),
      .err_sticky(err_sticky), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int pulses   = 0;

   // behavioural upstream counter
   logic [7:0] cnt = 8'h00;
   logic       cnt_en = 1'b0, cnt_dir = 1'b0;
   logic [7:0] glitch = 8'h00;
   logic       force_cout = 1'b0;

   // reference model state
   int m_prev, e_bin, e_err_cnt, e_wrap_cnt;
   bit m_en, m_dir, m_primed, e_valid, e_err, e_sticky;

   typedef struct {
      logic [7:0] gray;
      logic       cout;
      logic [7:0] exp_bin;
      logic       exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] enc8(input logic [7:0] v);
      return v ^ {1'b0, v[7:5], 1'b0, v[3:1]};
   endfunction

   function automatic int dec_nib(input int g);
      for (int b = 0; b < 16; b++)
         if ((b ^ (b >> 1)) == g) return b;
      return 0;
   endfunction

   function automatic int dec8(input logic [7:0] g);
      return dec_nib(int'(g[7:4])) * 16 + dec_nib(int'(g[3:0]));
   endfunction

   task automatic model_reset();
      m_prev = 0; m_en = 0; m_dir = 0; m_primed = 0;
      e_bin = 0; e_valid = 0; e_err = 0; e_sticky = 0; e_err_cnt = 0; e_wrap_cnt = 0;
   endtask

   task automatic model_edge();
      int  cur, want;
      bit  want_c, step_bad;
      cur   = dec8(gray_in);
      e_bin = cur;
      e_err = 0;
      if (clr) begin
         e_err_cnt = 0; e_wrap_cnt = 0; e_sticky = 0; e_valid = 0; m_primed = 0;
      end else if (!m_primed) begin
         e_valid = 1; m_primed = 1;
      end else begin
         want     = m_en ? (m_prev + (m_dir ? 1 : 255)) % 256 : m_prev;
         want_c   = en && (dir ? (cur == 255) : (cur == 0));
         step_bad = (cur != want);
         if (step_bad || (cout_in != want_c)) begin
            e_err = 1; e_sticky = 1; m_primed = 0;
            if (e_err_cnt < CNT_MAX) e_err_cnt++;
         end
         if (m_en && !step_bad &&
             ((m_dir && m_prev == 255 && cur == 0) || (!m_dir && m_prev == 0 && cur == 255)))
            if (e_wrap_cnt < CNT_MAX) e_wrap_cnt++;
      end
      m_prev = cur; m_en = en; m_dir = dir;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      cnt_en  = en;
      cnt_dir = dir;
      #1;
      check("bin_out", bin_out, e_bin);
      check("bin_valid", bin_valid, e_valid);
      check("step_err", step_err, e_err);
      check("err_sticky", err_sticky, e_sticky);
      check("err_cnt", err_cnt, e_err_cnt);
      check("wrap_cnt", wrap_cnt, e_wrap_cnt);
      if (step_err === 1'b1) pulses++;
   endtask

   task automatic drive_counter();
      gray_in = enc8(cnt) ^ glitch;
      cout_in = force_cout | (en & (dir ? (cnt == 8'hFF) : (cnt == 8'h00)));
   endtask

   task automatic run_cnt(input int n, input logic n_en, input logic n_dir);
      for (int i = 0; i < n; i++) begin
         cycle();
         en  = n_en;
         dir = n_dir;
         @(negedge clk);
         if (cnt_en) cnt = cnt_dir ? cnt + 8'd1 : cnt - 8'd1;
         drive_counter();
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_bin"}, bin_out, 0);
      check({tag, "_valid"}, bin_valid, 0);
      check({tag, "_serr"}, step_err, 0);
      check({tag, "_sticky"}, err_sticky, 0);
      check({tag, "_ecnt"}, err_cnt, 0);
      check({tag, "_wcnt"}, wrap_cnt, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   task automatic do_reset(input logic [7:0] start, input logic n_en, input logic n_dir);
      rst_n = 1'b0;
      clr = 1'b0; en = n_en; dir = n_dir; cnt = start; glitch = 8'h00; force_cout = 1'b0;
      drive_counter();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t tbl[14];
      int   p0;
      tbl[0]  = '{8'h0E, 1'b0, 8'h0B, 1'b0};
      tbl[1]  = '{8'h0A, 1'b0, 8'h0C, 1'b0};
      tbl[2]  = '{8'h0B, 1'b0, 8'h0D, 1'b0};
      tbl[3]  = '{8'h09, 1'b0, 8'h0E, 1'b0};
      tbl[4]  = '{8'h08, 1'b0, 8'h0F, 1'b0};
      tbl[5]  = '{8'h10, 1'b0, 8'h10, 1'b0};
      tbl[6]  = '{8'h13, 1'b0, 8'h12, 1'b1};
      tbl[7]  = '{8'h12, 1'b0, 8'h13, 1'b0};
      tbl[8]  = '{8'h16, 1'b0, 8'h14, 1'b0};
      tbl[9]  = '{8'h88, 1'b1, 8'hFF, 1'b1};
      tbl[10] = '{8'h00, 1'b0, 8'h00, 1'b0};
      tbl[11] = '{8'h01, 1'b0, 8'h01, 1'b0};
      tbl[12] = '{8'h03, 1'b1, 8'h02, 1'b1};
      tbl[13] = '{8'h02, 1'b0, 8'h03, 1'b0};

      model_reset();
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // raw vectors: decode, nibble carry, step and carry mismatches, ERR re-prime
      for (int i = 0; i < 14; i++) begin
         gray_in = tbl[i].gray; cout_in = tbl[i].cout; en = 1'b1; dir = 1'b1;
         cycle();
         check("tbl_bin", bin_out, tbl[i].exp_bin);
         check("tbl_err", step_err, tbl[i].exp_err);
      end

      do_reset(8'h00, 1'b1, 1'b1);
      run_cnt(20, 1'b1, 1'b1);
      check("up20_bin", bin_out, 8'd19);
      check("up20_err", err_cnt, 0);
      check("up20_wrap", wrap_cnt, 0);

      do_reset(8'hF8, 1'b1, 1'b1);
      run_cnt(12, 1'b1, 1'b1);
      check("upwrap_bin", bin_out, 8'h03);
      check("upwrap_wrap", wrap_cnt, 1);
      check("upwrap_err", err_cnt, 0);

      do_reset(8'h00, 1'b1, 1'b0);
      run_cnt(1, 1'b1, 1'b0);
      run_cnt(7, 1'b0, 1'b0);
      check("down_bin", bin_out, 8'hFE);
      check("down_wrap", wrap_cnt, 1);
      check("down_err", err_cnt, 0);

      // single low-nibble corruption 1 -> 3
      do_reset(8'h00, 1'b1, 1'b1);
      pulses = 0;
      run_cnt(1, 1'b1, 1'b1);
      glitch = 8'h01;
      run_cnt(1, 1'b1, 1'b1);
      glitch = 8'h00;
      run_cnt(12, 1'b1, 1'b1);
      check("glitch_pulses", pulses, 1);
      check("glitch_ecnt", err_cnt, 1);
      check("glitch_sticky", err_sticky, 1);

      // random controls with sporadic corruption and clears
      do_reset(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      for (int i = 0; i < 400; i++) begin
         cycle();
         en  = 1'($urandom_range(0, 3) != 0);
         dir = 1'($urandom_range(0, 1));
         clr = 1'($urandom_range(0, 31) == 0);
         @(negedge clk);
         if (cnt_en) cnt = cnt_dir ? cnt + 8'd1 : cnt - 8'd1;
         glitch = ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         drive_counter();
      end
      glitch = 8'h00;
      clr = 1'b0;
      drive_counter();
      run_cnt(3, 1'b1, 1'b1);

      // clear together with a corrupted sample: clear wins
      clr = 1'b1;
      glitch = 8'h10;
      drive_counter();
      glitch = 8'h00;
      p0 = pulses;
      run_cnt(1, 1'b1, 1'b1);
      clr = 1'b0;
      check("clr_ecnt", err_cnt, 0);
      check("clr_wcnt", wrap_cnt, 0);
      check("clr_valid", bin_valid, 0);
      check("clr_nopulse", pulses, p0);
      run_cnt(1, 1'b1, 1'b1);
      check("clr_valid_back", bin_valid, 1);
      run_cnt(5, 1'b1, 1'b1);

      // asynchronous reset mid-count
      cycle();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_zero("midrst");
      @(negedge clk);
      drive_counter();
      rst_n = 1'b1;
      run_cnt(6, 1'b1, 1'b1);

      // cout stuck high: repeated carry mismatches saturate the error count
      do_reset(8'h05, 1'b1, 1'b1);
      force_cout = 1'b1;
      drive_counter();
      run_cnt(560, 1'b1, 1'b1);
      check("sat_ecnt", err_cnt, CNT_MAX);
      check("sat_sticky", err_sticky, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Downstream checker for the 8-bit two-digit Gray up/down counter.
  - Low nibble is the fast digit; the high nibble steps when the low digit wraps.
- Decodes the counter's gray/cout outputs to binary.
- Checks every counter step against a model driven by the same en/dir controls.
- Counts step errors and wrap events for the display/debug stage that follows.

Parameters:
- CNT_W, 8, width of err_cnt and wrap_cnt; both saturate at all-ones.

Ports:
- clk  input  1  system clock; the monitor samples on the rising edge, and the counter updates on the falling edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of counters, error flag and FSM; takes priority over all other updates.
- en  input  1  same enable that drives the counter.
- dir  input  1  same direction that drives the counter: 1 = up, 0 = down.
- gray_in  input  8  counter gray output; [3:0] is the low digit, [7:4] is the high digit.
- cout_in  input  1  counter carry/borrow output.
- bin_out  output  8  registered binary value of gray_in.
- bin_valid  output  1  high once the monitor is primed.
- step_err  output  1  one-cycle pulse on a detected mismatch.
- err_sticky  output  1  set on the first error; held until clr or reset.
- err_cnt  output  CNT_W  saturating error count.
- wrap_cnt  output  CNT_W  saturating count of 255->0 and 0->255 wraps.

Behaviour:
- Decode is per nibble, standard 4-bit Gray to binary: b3=g3, b2=g3^g2, b1=b2^g1, b0=b1^g0.
  - cur_bin = {dec(gray_in[7:4]), dec(gray_in[3:0])}.
- Reset (async, rst_n=0): state=INIT and every output is 0. Internal regs prev_bin, en_q, dir_q are also 0.
- All register updates happen on the clk rising edge only.
- FSM states: INIT, TRACK, ERR.
- INIT, one cycle:
  - prev_bin<=cur_bin, bin_out<=cur_bin, bin_valid<=1.
  - en_q<=en, dir_q<=dir.
  - No check is performed -> TRACK.
- TRACK, every cycle:
  - Expected value: exp = en_q ? (dir_q ? prev_bin+1 : prev_bin-1) mod 256 : prev_bin.
  - Step mismatch: cur_bin != exp.
  - Carry mismatch: cout_in != (en & (dir ? cur_bin==8'hFF : cur_bin==8'h00)), evaluated on the current en/dir.
  - Either mismatch -> step_err=1 for that cycle, err_cnt+1 (saturating), err_sticky<=1, state -> ERR.
  - Wrap: en_q=1, no step mismatch, and either (dir_q=1, prev_bin=FF, cur_bin=00) or (dir_q=0, prev_bin=00, cur_bin=FF) -> wrap_cnt+1 (saturating).
  - Every cycle: prev_bin<=cur_bin, bin_out<=cur_bin, en_q<=en, dir_q<=dir.
- ERR, one cycle:
  - Behaves as INIT: re-primes prev_bin, en_q, dir_q; no check; err_sticky is held -> TRACK.
  - A single corruption therefore yields exactly one step_err pulse, not a cascade.
- clr=1:
  - err_cnt, wrap_cnt, err_sticky, step_err <= 0; bin_valid <= 0; state -> INIT.
  - bin_out keeps updating from cur_bin.
- Simultaneous clr and a detected error: clr wins; no count, no pulse.
- Saturation: a counter at all-ones stays all-ones. err_sticky still sets and step_err still pulses.
- Reset mid-operation: immediate return to the reset values. The first check happens two rising edges after rst_n deasserts.
- Latency:
  - bin_out is 1 cycle after gray_in.
  - step_err is asserted in the same cycle as the offending sample is registered, i.e. 1 cycle after the edge where gray_in is sampled.
- Input rule: en and dir change only just after the rising edge; the counter consumes them at the next falling edge.

Test Plan:
- Reset, then en=1, dir=1, 20 cycles from 00 -> bin_out follows 0..19 one cycle late; step_err never set; err_cnt=0, wrap_cnt=0.
- Count up through 255 (gray_in FF-coded high/low nibbles "1000_1000") -> bin_out FF then 00; wrap_cnt=1; cout_in high at FF accepted with no error.
- Down count from 00 with en=1, dir=0 -> bin_out FF; wrap_cnt=1; then en=0 for 5 cycles -> bin_out holds FE with no error.
- Force a low-nibble gray jump from 1 to 3 mid-count -> one step_err pulse, err_cnt=1, err_sticky=1. After the ERR re-prime, the following correct steps raise no further errors.
- Tie cout_in=1 while counting up at value 05 -> carry mismatch, err_cnt increments by 1 per resync, saturating at 255 after 255+ errors.
- Assert clr with err_cnt=3, wrap_cnt=2 -> both 0 next cycle, bin_valid=0 for one cycle, then 1. Assert rst_n=0 mid-count -> all outputs 0 immediately.
